// File: rtl/rr_sel_seq_pkg.sv
// Shared definitions for the round-robin selection sequencer.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   state_e : two-state sequencer FSM encoding
package rr_sel_seq_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick over 16 requesters.
// Ports:
//   req   [15:0] in  : request lines, bit i requests index i
//   ptr   [3:0]  in  : highest-priority index for this pick
//   idx   [3:0]  out : first requesting index scanning ptr, ptr+1, ... (mod 16)
//   found        out : at least one request is present
module rr_pick16
  import rr_sel_seq_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotate so that bit 0 of rot is req[ptr]; bit i is req[(ptr+i) mod 16].
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  // Lowest set bit of the rotated vector is the offset from ptr.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
  end

  // 4-bit add wraps naturally back into the 0..15 index space.
  assign idx   = ptr + off;
  assign found = |req;

endmodule

// File: rtl/rr_sel_seq.sv
// 16-requester round-robin selection sequencer feeding a 4-to-16 decoder.
// A winner is held for a programmable dwell, followed by a one-cycle idle gap
// (with sel_done) during which the next winner is arbitrated.
// Ports:
//   clk        in            : rising-edge clock
//   rst        in            : synchronous active-high reset
//   req_in     in  [15:0]    : request lines
//   hold_cyc   in  [HOLD_W]  : dwell length in cycles, sampled at grant (0 acts as 1)
//   release_in in            : early termination of the current grant
//   sel_out    out [3:0]     : registered index of the current winner
//   sel_en     out           : registered, high while a grant is active
//   sel_done   out           : registered one-cycle pulse after each grant ends
module rr_sel_seq
  import rr_sel_seq_pkg::*;
#(
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_in,
  input  logic [HOLD_W-1:0] hold_cyc,
  input  logic              release_in,
  output logic [IDX_W-1:0]  sel_out,
  output logic              sel_en,
  output logic              sel_done
);

  state_e            state;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] hold_m1;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              grant_end;

  rr_pick16 u_pick (
    .req   (req_in),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // cnt counts remaining high cycles after the current one, so load H-1.
  assign hold_m1 = (hold_cyc == '0) ? '0 : hold_cyc - HOLD_W'(1);

  // Current cycle is the last high one: dwell expired, released, or requester gone.
  assign grant_end = (cnt == '0) | release_in | ~req_in[sel_out];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_out  <= '0;
      sel_en   <= 1'b0;
      sel_done <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          sel_done <= 1'b0;
          if (pick_found) begin
            state   <= ST_GRANT;
            sel_out <= pick_idx;
            sel_en  <= 1'b1;
            cnt     <= hold_m1;
          end
        end
        ST_GRANT: begin
          if (grant_end) begin
            state    <= ST_IDLE;
            sel_en   <= 1'b0;
            sel_done <= 1'b1;
            ptr      <= sel_out + IDX_W'(1);
          end else begin
            cnt <= cnt - HOLD_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          sel_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_sel_seq.md
Name: rr_sel_seq

Overview:
- 16-requester round-robin selection sequencer that produces the 4-bit index and enable consumed by the 4-to-16 one-hot decode stage.
- Picks one active requester and presents its index with an enable for a programmable dwell time.
- Forces a one-cycle idle gap, then advances priority past the last winner.
- Sits directly upstream of the decoder: sel_out drives its 4-bit input, sel_en drives its enable.

Parameters:
- HOLD_W, 8, width of the dwell-count input and internal down-counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_in  input  16  request lines; bit i requests index i.
- hold_cyc  input  HOLD_W  dwell length in cycles; sampled at grant.
- release_in  input  1  early-termination strobe for the current grant.
- sel_out  output  4  registered index of the current winner.
- sel_en  output  1  registered; high while a grant is active.
- sel_done  output  1  registered one-cycle pulse after each grant ends.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, sel_out=0, sel_en=0, sel_done=0, ptr=0, cnt=0.
  - Reset mid-grant aborts the grant with no sel_done pulse.
- States: IDLE and GRANT (2-state FSM).
- Pick: combinational, from req_in and ptr. Winner is the first set bit scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
- IDLE:
  - sel_en=0.
  - If req_in != 0: on the next edge go to GRANT, sel_out=winner, sel_en=1, cnt=H-1, where H=max(hold_cyc,1).
  - If req_in == 0: stay in IDLE.
- GRANT: each cycle evaluate end = (cnt==0) | release_in | ~req_in[sel_out].
  - If end: this is the last sel_en-high cycle. Next edge: IDLE, sel_en=0, sel_done=1, ptr=(sel_out+1) mod 16 (4-bit wrap, 15→0).
  - Else: cnt decrements.
- sel_done: high only in the first IDLE cycle after a grant; deasserts the following edge.
- sel_out holds its last value while sel_en=0.
- Latency:
  - Request visible in an IDLE cycle → sel_en high from the next cycle.
  - Full dwell gives exactly H cycles of sel_en high.
  - Minimum gap between grants is 1 cycle (the IDLE/sel_done cycle), which also arbitrates. Back-to-back grant period = H+1 cycles.
- Boundary conditions:
  - hold_cyc=0 behaves as 1.
  - Changes to hold_cyc during GRANT are ignored.
  - release_in in IDLE is ignored.
  - release_in coincident with cnt==0 is a single end event: one sel_done.
  - Requester drop: if req_in[sel_out] falls in a GRANT cycle, that cycle is the last high cycle.
  - New or other requests during GRANT never preempt.
  - A sole persistent requester is regranted every H+1 cycles.

Decomposition:
- Shared package: N_REQ=16, IDX_W=4, state encodings ST_IDLE/ST_GRANT.
- One combinational sub-module, rr_pick16: inputs req[15:0], ptr[3:0]; outputs idx[3:0], found.
  - Implement as a rotate, then priority-encode, then add ptr mod 16.
- Top level holds the FSM, counter, pointer and output registers.

Test Plan:
- Single requester, full dwell: req_in=0x0001, hold_cyc=3 → sel_out=0, sel_en high 3 cycles, 1 low cycle with sel_done=1, then regrant of index 0; period 4 cycles.
- Wrap-around fairness: req_in=0x8001, hold_cyc=2, from reset → grant order 0, 15, 0, 15; ptr wraps 15→0.
- Early release: req_in=0x0010, hold_cyc=10, release_in pulsed in the 2nd high cycle → sel_en high exactly 2 cycles, sel_out=4, sel_done next cycle, ptr=5.
- Requester drop plus priority: req_in=0x0104; drop bit 2 in the 1st high cycle → grant to 2 lasts 1 cycle, gap 1 cycle, next grant sel_out=8; hold_cyc=0 → every grant exactly 1 cycle.
- Reset mid-grant: req_in=0x0040, hold_cyc=5, rst high in the 3rd high cycle → next cycle sel_en=0, sel_out=0, sel_done=0; after rst falls, grant to 6 resumes from ptr=0 scan.
- No requests / ignored inputs: req_in=0 with release_in toggling and hold_cyc changing → sel_en and sel_done stay 0 indefinitely.
